// File: rtl/avg_sched.sv
// Sequencer for the 8-lane averaging tree: done lands BEATS+RD_LAT+TREE_LAT+2 cycles after start accept; no backpressure.
// Define AVG_SCHED_ABORT_EN to add abort_i, which cancels an in-flight average without a done pulse.
module avg_sched #(
    parameter int BEATS    = 32,
    parameter int AW       = 5,
    parameter int RD_LAT   = 1,
    parameter int TREE_LAT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
`ifdef AVG_SCHED_ABORT_EN
    input  logic          abort_i,
`endif
    output logic          busy_o,
    output logic          done_o,
    output logic [7:0]    avg_o,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_o,
    input  logic [63:0]   rd_data_i,
    output logic          tree_clr_o,
    output logic          tree_in_valid_o,
    output logic [63:0]   tree_in_o,
    input  logic [15:0]   tree_sum_i
);

    localparam int CW = (TREE_LAT > 1) ? $clog2(TREE_LAT) : 1;
    localparam logic [AW-1:0] LAST_BEAT = AW'(BEATS - 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(TREE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     beat_q, beat_d;
    logic [RD_LAT-1:0] vpipe_q, vpipe_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [7:0]        avg_q, avg_d;
    logic              abort_hit;

`ifdef AVG_SCHED_ABORT_EN
    assign abort_hit = abort_i && (state_q inside {S_CLEAR, S_FETCH, S_DRAIN});
`else
    assign abort_hit = 1'b0;
`endif

    assign busy_o          = (state_q != S_IDLE);
    assign done_o          = (state_q == S_DONE);
    assign tree_clr_o      = (state_q == S_CLEAR);
    assign rd_en_o         = (state_q == S_FETCH);
    assign rd_addr_o       = rd_en_o ? beat_q : '0;
    assign tree_in_valid_o = vpipe_q[RD_LAT-1];
    assign tree_in_o       = rd_data_i;
    assign avg_o           = avg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            vpipe_q <= '0;
            cnt_q   <= '0;
            avg_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            vpipe_q <= vpipe_d;
            cnt_q   <= cnt_d;
            avg_q   <= avg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        avg_d   = avg_q;
        // The valid pipe mirrors RAM read latency so tree_in_valid lines up with rd_data.
        vpipe_d = (vpipe_q << 1) | RD_LAT'(rd_en_o);

        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                beat_d  = '0;
                cnt_d   = '0;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (beat_q == LAST_BEAT) state_d = S_DRAIN;
                else                     beat_d  = beat_q + AW'(1);
            end
            S_DRAIN: begin
                // Tree latency is only counted once the last beat has left the valid pipe.
                if (vpipe_q == '0) begin
                    if (cnt_q == LAST_CNT) begin
                        avg_d   = 8'((17'(tree_sum_i) + 17'd128) >> 8);
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_hit) begin
            state_d = S_IDLE;
            vpipe_d = '0;
            avg_d   = avg_q;
        end
    end

endmodule
